pq_access_scheduler: RTL and testbench

PQ_ACCESS_SCHEDULER -- requirements
Module: pq_access_scheduler

---
 rtl/pq_sched_pkg.sv | 14 +
 rtl/pq_rr_arbiter.sv | 36 +++
 rtl/pq_access_scheduler.sv | 155 +++++++++++++++
 tb/tb_pq_access_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pq_sched_pkg.sv
// Shared types and defaults for the priority-queue access scheduler.
package pq_sched_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } pq_sched_state_e;

    localparam int CNT_WIDTH         = 4;
    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_SETTLE_CYCLES = 2;

endpackage

// File: rtl/pq_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after rr_ptr.
module pq_rr_arbiter
#(
    parameter int NUM_REQ = 4
)
(
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic found_s;
    int   idx_s;

    // Scan requesters in rotated order starting from rr_ptr.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        idx_s     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[idx_s] && !found_s) begin
                grant[idx_s] = 1'b1;
                grant_idx    = IDX_W'(idx_s);
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/pq_access_scheduler.sv
// Arbitrates replace requests from several requesters onto one priority queue,
// enforcing idle settle cycles. Define PQ_SCHED_STATS_EN to add replace/stall counters.
module pq_access_scheduler
    import pq_sched_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
)
(
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          hold,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_entry,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          resp_valid,
    output logic [$clog2(NUM_REQ)-1:0]    resp_id,
    output logic [DATA_WIDTH-1:0]         resp_entry,
    output logic                          pq_replace,
    output logic [DATA_WIDTH-1:0]         pq_new_entry,
    input  logic [DATA_WIDTH-1:0]         pq_max_entry
`ifdef PQ_SCHED_STATS_EN
    ,
    output logic [31:0]                   stat_replaces,
    output logic [31:0]                   stat_stalls
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    pq_sched_state_e        state_r;
    pq_sched_state_e        state_next_s;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic [IDX_W-1:0]       rr_ptr_r;
    logic                   resp_valid_r;
    logic [IDX_W-1:0]       resp_id_r;
    logic [DATA_WIDTH-1:0]  resp_entry_r;
    logic [NUM_REQ-1:0]     arb_grant_s;
    logic [IDX_W-1:0]       arb_idx_s;
    logic                   grant_en_s;

    pq_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_r),
        .grant     (arb_grant_s),
        .grant_idx (arb_idx_s)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: leave SETTLE on the cycle the counter reaches zero.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_en_s) begin
                    state_next_s = SETTLE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SETTLE: begin
                if (cnt_r <= CNT_WIDTH'(1)) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SETTLE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output logic: grant, replace strobe and new entry are combinational.
    always_comb begin
        grant_en_s   = 1'b0;
        req_ready    = '0;
        pq_replace   = 1'b0;
        pq_new_entry = '0;
        case (state_r)
            IDLE: begin
                if (!RST && !hold && (|req_valid)) begin
                    grant_en_s   = 1'b1;
                    req_ready    = arb_grant_s;
                    pq_replace   = 1'b1;
                    pq_new_entry = req_entry[arb_idx_s*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    grant_en_s = 1'b0;
                end
            end
            SETTLE:  grant_en_s = 1'b0;
            default: grant_en_s = 1'b0;
        endcase
    end

    // Settle counter, round-robin pointer and the registered response.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r        <= '0;
            rr_ptr_r     <= '0;
            resp_valid_r <= 1'b0;
            resp_id_r    <= '0;
            resp_entry_r <= '0;
        end else if (grant_en_s) begin
            cnt_r        <= CNT_WIDTH'(SETTLE_CYCLES);
            rr_ptr_r     <= (arb_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx_s + IDX_W'(1);
            resp_valid_r <= 1'b1;
            resp_id_r    <= arb_idx_s;
            resp_entry_r <= pq_max_entry;
        end else begin
            resp_valid_r <= 1'b0;
            if (state_r == SETTLE && cnt_r != '0) begin
                cnt_r <= cnt_r - CNT_WIDTH'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_id    = resp_id_r;
    assign resp_entry = resp_entry_r;

`ifdef PQ_SCHED_STATS_EN
    logic [31:0] stat_replaces_r;
    logic [31:0] stat_stalls_r;

    // Free-running wrap-around usage counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_replaces_r <= 32'd0;
            stat_stalls_r   <= 32'd0;
        end else if (grant_en_s) begin
            stat_replaces_r <= stat_replaces_r + 32'd1;
        end else if (|req_valid) begin
            stat_stalls_r <= stat_stalls_r + 32'd1;
        end else begin
            stat_replaces_r <= stat_replaces_r;
        end
    end

    assign stat_replaces = stat_replaces_r;
    assign stat_stalls   = stat_stalls_r;
`endif

endmodule

// File: tb/tb_pq_access_scheduler.sv
// Directed bench for pq_access_scheduler with a cycle-level reference model.
module tb_pq_access_scheduler;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int SC = 2;

    logic            CLK = 1'b0;
    logic            RST;
    logic            hold;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_entry;
    logic [N-1:0]    req_ready;
    logic            resp_valid;
    logic [1:0]      resp_id;
    logic [DW-1:0]   resp_entry;
    logic            pq_replace;
    logic [DW-1:0]   pq_new_entry;
    logic [DW-1:0]   pq_max_entry;
`ifdef PQ_SCHED_STATS_EN
    logic [31:0]     stat_replaces;
    logic [31:0]     stat_stalls;
`endif

    int checks = 0;
    int errors = 0;

    pq_access_scheduler #(
        .NUM_REQ       (N),
        .DATA_WIDTH    (DW),
        .SETTLE_CYCLES (SC)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .hold         (hold),
        .req_valid    (req_valid),
        .req_entry    (req_entry),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_id      (resp_id),
        .resp_entry   (resp_entry),
        .pq_replace   (pq_replace),
        .pq_new_entry (pq_new_entry),
        .pq_max_entry (pq_max_entry)
`ifdef PQ_SCHED_STATS_EN
        ,
        .stat_replaces (stat_replaces),
        .stat_stalls   (stat_stalls)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: a cooldown count, a fairness pointer and the last response.
    int            m_gap = 0;
    int            m_ptr = 0;
    bit            m_on  = 1'b0;
    bit            m_rv  = 1'b0;
    int            m_rid = 0;
    logic [DW-1:0] m_rent = '0;
    int unsigned   m_rep = 0;
    int unsigned   m_stall = 0;

    always @(negedge CLK) begin
        int  g;
        bit  found;
        bit  allow;
        g = 0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_valid[(m_ptr + k) % N]) begin
                g = (m_ptr + k) % N;
                found = 1'b1;
            end
        end
        allow = !RST && (m_gap == 0) && !hold && found;
        if (m_on) begin
            chk("m_ready", 32'(req_ready), allow ? (32'd1 << g) : 32'd0);
            chk("m_replace", 32'(pq_replace), 32'(allow));
            chk("m_new_entry", 32'(pq_new_entry), allow ? 32'(req_entry[g*DW +: DW]) : 32'd0);
            chk("m_resp_valid", 32'(resp_valid), 32'(m_rv));
            if (m_rv) begin
                chk("m_resp_id", 32'(resp_id), 32'(m_rid));
                chk("m_resp_entry", 32'(resp_entry), 32'(m_rent));
            end
`ifdef PQ_SCHED_STATS_EN
            chk("m_stat_replaces", stat_replaces, 32'(m_rep));
            chk("m_stat_stalls", stat_stalls, 32'(m_stall));
`endif
        end
        if (RST) begin
            m_on = 1'b1; m_gap = 0; m_ptr = 0; m_rv = 1'b0; m_rid = 0; m_rent = '0;
            m_rep = 0; m_stall = 0;
        end else if (allow) begin
            m_rv = 1'b1; m_rid = g; m_rent = pq_max_entry;
            m_ptr = (g + 1) % N; m_gap = SC; m_rep++;
        end else begin
            m_rv = 1'b0;
            if (m_gap > 0) m_gap--;
            if (|req_valid) m_stall++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int got[$];
        int exp_order[5];
`ifdef PQ_SCHED_STATS_EN
        logic [31:0] rep0, stall0;
`endif
        exp_order = '{0, 1, 2, 3, 0};
        RST = 1'b1; hold = 1'b0; req_valid = '0; req_entry = '0; pq_max_entry = '0;
        tick(); tick();

        // Requests must be ignored while reset is held.
        req_valid = 4'b1111;
        @(negedge CLK);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_replace", 32'(pq_replace), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_entry", 32'(resp_entry), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);

        // Single request.
        tick();
        RST = 1'b0; req_valid = 4'b0001; req_entry[15:0] = 16'd55; pq_max_entry = 16'd90;
        @(negedge CLK);
        chk("single_ready", 32'(req_ready), 32'h1);
        chk("single_replace", 32'(pq_replace), 32'd1);
        chk("single_new_entry", 32'(pq_new_entry), 32'd55);
        tick();
        req_valid = 4'b0000;
        @(negedge CLK);
        chk("single_resp_valid", 32'(resp_valid), 32'd1);
        chk("single_resp_id", 32'(resp_id), 32'd0);
        chk("single_resp_entry", 32'(resp_entry), 32'd90);
        chk("single_idle_new_entry", 32'(pq_new_entry), 32'd0);
        repeat (3) tick();

        // Spacing: a held request is replaced every SC+1 cycles.
        req_valid = 4'b0001;
        for (int i = 0; i < 9; i++) begin
            pq_max_entry = 16'(16'h0a00 + i);
            @(negedge CLK);
            chk("spacing", 32'(pq_replace), 32'((i % 3) == 0));
`ifdef PQ_SCHED_STATS_EN
            if (i == 0) begin
                rep0 = stat_replaces; stall0 = stat_stalls;
            end
`endif
            tick();
        end
`ifdef PQ_SCHED_STATS_EN
        @(negedge CLK);
        chk("stat_replaces_9", stat_replaces - rep0, 32'd3);
        chk("stat_stalls_9", stat_stalls - stall0, 32'd6);
        tick();
`endif

        // Fairness from a fresh reset.
        req_valid = 4'b0000; RST = 1'b1;
        tick();
        RST = 1'b0; req_valid = 4'b1111;
        req_entry = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
        for (int i = 0; i < 40 && got.size() < 5; i++) begin
            pq_max_entry = 16'(16'h0300 + 7 * i);
            @(negedge CLK);
            if (pq_replace) begin
                for (int j = 0; j < N; j++) if (req_ready[j]) got.push_back(j);
            end
            tick();
        end
        chk("fair_count", 32'(got.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (got.size() > k) chk("fair_order", 32'(got[k]), 32'(exp_order[k]));
        end

        // Hold blocks new grants; release grants requester 2 at once.
        req_valid = 4'b0000;
        repeat (4) tick();
        hold = 1'b1; req_valid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("hold_replace", 32'(pq_replace), 32'd0);
            tick();
        end
        hold = 1'b0;
        @(negedge CLK);
        chk("hold_release_ready", 32'(req_ready), 32'h4);
        chk("hold_release_entry", 32'(pq_new_entry), 32'h0102);

        // Reset one cycle after the grant abandons the settle.
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0; req_valid = 4'b1111;
        @(negedge CLK);
        chk("rst_settle_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_settle_ready", 32'(req_ready), 32'h1);
        chk("rst_settle_replace", 32'(pq_replace), 32'd1);

        // A request withdrawn during settle leaves no trace.
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("drop_replace", 32'(pq_replace), 32'd0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
